sm_timer: RTL and testbench

Memory-mapped timer/compare peripheral that answers CPU data-memory bus accesses. It decodes a 32-byte window of the data address space and returns read data combinationally in the same cycle, as the single-cycle core's `lw` requires. It captures writes on the next rising clock edge. It runs a prescaled 32-bit counter with compare match, auto-reload or one-shot mode, a sticky match flag and a level interrupt.

---
 rtl/sm_timer.sv | 151 +++++++++++++++
 tb/tb_sm_timer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_timer.sv
// sm_timer: memory-mapped prescaled 32-bit timer with compare match,
// auto-reload / one-shot modes, a sticky match flag and a level interrupt.
// Bus reads are combinational; writes land on the next rising edge.
module sm_timer #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        irq
);

    localparam int unsigned DW = 32;
    localparam int unsigned PW = 16;
    localparam int unsigned CW = 3;

    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_PRESC   = 3'd1;
    localparam logic [2:0] OFF_COUNT   = 3'd2;
    localparam logic [2:0] OFF_COMPARE = 3'd3;
    localparam logic [2:0] OFF_STATUS  = 3'd4;

    // CTRL bit positions
    localparam int unsigned B_EN = 0;
    localparam int unsigned B_AR = 1;
    localparam int unsigned B_IE = 2;

    logic [CW-1:0] ctrl_q,    ctrl_d;
    logic [PW-1:0] presc_q,   presc_d;
    logic [PW-1:0] pcnt_q,    pcnt_d;
    logic [DW-1:0] count_q,   count_d;
    logic [DW-1:0] compare_q, compare_d;
    logic          flag_q,    flag_d;
    logic          irq_q,     irq_d;

    logic          sel_c;
    logic [2:0]    off_c;
    logic          wr_c;
    logic          tick_c;
    logic          match_c;

    // Byte-lane bits of the address carry no meaning in this window.
    logic          unused_addr;
    assign unused_addr = ^addr[1:0];

    // Window decode and per-cycle event qualifiers.
    always_comb begin
        sel_c   = (addr[31:5] == BASE[31:5]);
        off_c   = addr[4:2];
        wr_c    = we & sel_c;
        tick_c  = ctrl_q[B_EN] & (pcnt_q == PW'(0));
        match_c = (count_q == compare_q);
    end

    // Combinational read mux; reflects register state before the edge.
    always_comb begin
        rdata = '0;
        if (sel_c) begin
            case (off_c)
                OFF_CTRL:    rdata = DW'(ctrl_q);
                OFF_PRESC:   rdata = DW'(presc_q);
                OFF_COUNT:   rdata = count_q;
                OFF_COMPARE: rdata = compare_q;
                OFF_STATUS:  rdata = DW'(flag_q);
                default:     rdata = '0;
            endcase
        end
    end

    // Next-state: tick updates first, bus writes layered on top by priority.
    always_comb begin
        ctrl_d    = ctrl_q;
        presc_d   = presc_q;
        pcnt_d    = pcnt_q;
        count_d   = count_q;
        compare_d = compare_q;
        flag_d    = flag_q;

        // Prescaler runs only while enabled.
        if (tick_c) begin
            pcnt_d = presc_q;
        end else if (ctrl_q[B_EN]) begin
            pcnt_d = pcnt_q - PW'(1);
        end

        // Counter / compare behaviour on a tick.
        if (tick_c) begin
            if (match_c) begin
                if (ctrl_q[B_AR]) begin
                    count_d = '0;
                end else begin
                    ctrl_d[B_EN] = 1'b0;
                end
            end else begin
                count_d = count_q + DW'(1);
            end
        end

        // Bus writes override the tick-driven values of the same register.
        if (wr_c) begin
            case (off_c)
                OFF_CTRL:    ctrl_d    = wdata[CW-1:0];
                OFF_PRESC:   presc_d   = wdata[PW-1:0];
                OFF_COUNT:   count_d   = wdata;
                OFF_COMPARE: compare_d = wdata;
                OFF_STATUS:  if (wdata[0]) flag_d = 1'b0;
                default:     ;
            endcase
            // Reprogramming CTRL or PRESC restarts the prescale period.
            if (off_c == OFF_CTRL || off_c == OFF_PRESC) begin
                pcnt_d = presc_d;
            end
        end

        // A match wins over a simultaneous write-1-to-clear.
        if (tick_c && match_c) begin
            flag_d = 1'b1;
        end

        irq_d = flag_d & ctrl_d[B_IE];
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            presc_q   <= '0;
            pcnt_q    <= '0;
            count_q   <= '0;
            compare_q <= '1;
            flag_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            presc_q   <= presc_d;
            pcnt_q    <= pcnt_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            flag_q    <= flag_d;
            irq_q     <= irq_d;
        end
    end

    assign sel = sel_c;
    assign irq = irq_q;

endmodule

// File: tb/tb_sm_timer.sv
// Testbench for sm_timer: directed scenarios with literal expectations plus
// randomized bus traffic checked every cycle against a behavioural model.
module tb_sm_timer;

    localparam logic [31:0] BASE = 32'h0000_7F00;
    localparam logic [31:0] R_CTRL = 32'h00, R_PRESC = 32'h04, R_COUNT = 32'h08,
                            R_COMPARE = 32'h0C, R_STATUS = 32'h10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        sel;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;

    sm_timer #(.BASE(BASE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .sel   (sel),
        .irq   (irq)
    );

    always #10 clk = ~clk;

    // Behavioural view of the peripheral: the programmer-visible registers
    // plus the hidden prescale down-counter.
    typedef struct packed {
        logic        en, ar, ie, flag;
        logic [15:0] presc, pcnt;
        logic [31:0] count, compare;
    } model_t;

    localparam model_t M_RESET = '{en: 1'b0, ar: 1'b0, ie: 1'b0, flag: 1'b0,
                                   presc: 16'h0, pcnt: 16'h0,
                                   count: 32'h0, compare: 32'hFFFF_FFFF};

    model_t m;

    function automatic logic in_window(input logic [31:0] a);
        return (a >> 5) == (BASE >> 5);
    endfunction

    // One clock edge of the timer described as rules on the register file.
    function automatic model_t model_next(input model_t s, input logic [31:0] a,
                                          input logic w, input logic [31:0] d);
        model_t n = s;
        int     reg_idx = int'(a[4:2]);
        logic   wr = w && in_window(a);
        logic   ticking = s.en && (s.pcnt == 16'd0);
        logic   hit = ticking && (s.count == s.compare);
        longint next_cnt;

        if (ticking)    n.pcnt = s.presc;
        else if (s.en)  n.pcnt = s.pcnt - 16'd1;

        if (ticking && !hit) begin
            next_cnt = (longint'(s.count) + 1) % 64'h1_0000_0000;
            n.count  = 32'(next_cnt);
        end
        if (hit && s.ar)  n.count = 32'd0;
        if (hit && !s.ar) n.en = 1'b0;

        if (wr) begin
            if (reg_idx == 0) begin
                n.en = d[0]; n.ar = d[1]; n.ie = d[2];
            end
            if (reg_idx == 1) n.presc   = d[15:0];
            if (reg_idx == 2) n.count   = d;
            if (reg_idx == 3) n.compare = d;
            if (reg_idx == 4 && d[0]) n.flag = 1'b0;
            if (reg_idx == 0 || reg_idx == 1) n.pcnt = n.presc;
        end
        if (hit) n.flag = 1'b1;
        return n;
    endfunction

    function automatic logic [31:0] model_read(input model_t s, input logic [31:0] a);
        if (!in_window(a)) return 32'h0;
        case (int'(a[4:2]))
            0:       return {29'h0, s.ie, s.ar, s.en};
            1:       return {16'h0, s.presc};
            2:       return s.count;
            3:       return s.compare;
            4:       return {31'h0, s.flag};
            default: return 32'h0;
        endcase
    endfunction

    // Model state tracks the DUT edge for edge, including async reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= M_RESET;
        else        m <= model_next(m, addr, we, wdata);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Advance one clock: compare outputs with the model mid-cycle, then
    // return just after the next rising edge.
    task automatic cycle();
        @(negedge clk);
        chk("model_sel",   32'(sel),   32'(in_window(addr)));
        chk("model_rdata", rdata,      model_read(m, addr));
        chk("model_irq",   32'(irq),   32'(m.flag & m.ie));
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] off, input logic [31:0] d);
        addr  = BASE + off;
        wdata = d;
        we    = 1'b1;
        cycle();
        we    = 1'b0;
    endtask

    task automatic rdchk(input string name, input logic [31:0] off, input logic [31:0] exp);
        addr = BASE + off;
        we   = 1'b0;
        #1;
        chk(name, rdata, exp);
    endtask

    logic [31:0] ar_cnt [8] = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    logic [31:0] ps_cnt [6] = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd2};
    logic [31:0] wr_cnt [3] = '{32'hFFFF_FFFF, 32'd0, 32'd1};

    initial begin
        rst_n = 1'b0;
        addr  = BASE;
        we    = 1'b0;
        wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("irq_in_reset", 32'(irq), 32'd0);
        rst_n = 1'b1;

        // Reset values and window decode
        rdchk("rst_ctrl",    R_CTRL,    32'h0);
        rdchk("rst_presc",   R_PRESC,   32'h0);
        rdchk("rst_count",   R_COUNT,   32'h0);
        rdchk("rst_compare", R_COMPARE, 32'hFFFF_FFFF);
        rdchk("rst_status",  R_STATUS,  32'h0);
        addr = BASE + 32'h20;
        #1;
        chk("outside_sel",   32'(sel), 32'd0);
        chk("outside_rdata", rdata,    32'h0);
        bus_write(32'h20, 32'h7);
        bus_write(32'h28, 32'h55);
        rdchk("outside_wr_ctrl",  R_CTRL,  32'h0);
        rdchk("outside_wr_count", R_COUNT, 32'h0);
        rdchk("reserved_rd",      32'h14,  32'h0);

        // Auto-reload with COMPARE = 3
        bus_write(R_COMPARE, 32'd3);
        bus_write(R_CTRL, 32'h7);
        rdchk("ar_e0", R_COUNT, 32'd0);
        for (int i = 0; i < 8; i++) begin
            cycle();
            rdchk("ar_count", R_COUNT, ar_cnt[i]);
            if (i == 3 || i == 7) begin
                rdchk("ar_flag", R_STATUS, 32'd1);
                chk("ar_irq", 32'(irq), 32'd1);
            end
        end
        bus_write(R_CTRL, 32'h0);
        bus_write(R_STATUS, 32'h1);
        bus_write(R_COUNT, 32'h0);
        chk("ar_irq_clr", 32'(irq), 32'd0);

        // One-shot with COMPARE = 2
        bus_write(R_COMPARE, 32'd2);
        bus_write(R_CTRL, 32'h1);
        repeat (3) cycle();
        rdchk("os_count",  R_COUNT,  32'd2);
        rdchk("os_ctrl",   R_CTRL,   32'd0);
        rdchk("os_flag",   R_STATUS, 32'd1);
        chk("os_irq", 32'(irq), 32'd0);
        repeat (10) cycle();
        rdchk("os_hold", R_COUNT, 32'd2);
        bus_write(R_STATUS, 32'h1);

        // Prescaler = 2, then reprogrammed to 0 mid-count
        bus_write(R_COUNT, 32'h0);
        bus_write(R_COMPARE, 32'hFFFF_FFFF);
        bus_write(R_PRESC, 32'hABCD_0002);
        rdchk("presc_upper", R_PRESC, 32'h2);
        bus_write(R_CTRL, 32'h1);
        rdchk("ps_e0", R_COUNT, 32'd0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            rdchk("ps_count", R_COUNT, ps_cnt[i]);
        end
        bus_write(R_PRESC, 32'h0);
        rdchk("ps0_e7", R_COUNT, 32'd2);
        cycle();
        rdchk("ps0_e8", R_COUNT, 32'd3);
        cycle();
        rdchk("ps0_e9", R_COUNT, 32'd4);

        // COUNT write on a tick edge wins over the increment
        bus_write(R_COUNT, 32'h100);
        rdchk("col_count_wr", R_COUNT, 32'h100);
        cycle();
        rdchk("col_count_next", R_COUNT, 32'h101);

        // STATUS clear on a match edge loses; a later clear wins
        bus_write(R_CTRL, 32'h0);
        bus_write(R_COUNT, 32'd5);
        bus_write(R_COMPARE, 32'd7);
        bus_write(R_CTRL, 32'h5);
        repeat (2) cycle();
        rdchk("col_pre", R_COUNT, 32'd7);
        bus_write(R_STATUS, 32'h1);
        rdchk("col_flag_kept", R_STATUS, 32'd1);
        chk("col_irq_kept", 32'(irq), 32'd1);
        rdchk("col_os_ctrl", R_CTRL, 32'h4);
        bus_write(R_STATUS, 32'h1);
        rdchk("col_flag_clr", R_STATUS, 32'd0);
        chk("col_irq_clr", 32'(irq), 32'd0);

        // 32-bit wrap without a flag
        bus_write(R_CTRL, 32'h0);
        bus_write(R_COMPARE, 32'd5);
        bus_write(R_COUNT, 32'hFFFF_FFFE);
        bus_write(R_CTRL, 32'h1);
        rdchk("wrap_e0", R_COUNT, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            cycle();
            rdchk("wrap_count", R_COUNT, wr_cnt[i]);
            rdchk("wrap_flag",  R_STATUS, 32'd0);
        end
        bus_write(R_CTRL, 32'h0);

        // Randomized traffic with occasional asynchronous reset
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) < 7) addr = BASE + 32'($urandom_range(0, 31));
            else                          addr = $urandom;
            we = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) wdata = $urandom;
            else                           wdata = 32'($urandom_range(0, 12));
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                cycle();
                cycle();
                rst_n = 1'b1;
            end else begin
                cycle();
            end
        end
        we = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
